// File: rtl/issue_sched_pkg.sv
// Shared definitions for the issue scheduler: FSM encoding, padding modes
// and default datapath widths.
package issue_sched_pkg;

  localparam int COORD_W_DEF = 8;
  localparam int DEPTH_W_DEF = 9;

  localparam logic PAD_VALID = 1'b0;
  localparam logic PAD_SAME  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSIGN = 2'd1,
    ST_STREAM = 2'd2,
    ST_FINISH = 2'd3
  } sched_state_t;

endpackage

// File: rtl/issue_raster_cnt.sv
// Three-level (z outer, y middle, x inner) raster counter. Bounds are latched
// on load so the caller may change them while the count runs; y wraps back to
// its latched start value rather than zero.
module issue_raster_cnt #(
  parameter int XW = 8,
  parameter int YW = 8,
  parameter int ZW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [YW-1:0] y_first,
  input  logic [YW-1:0] y_last,
  input  logic [XW-1:0] x_last,
  input  logic [ZW-1:0] z_last,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [ZW-1:0] z,
  output logic          last
);

  logic [YW-1:0] y_first_r;
  logic [YW-1:0] y_last_r;
  logic [XW-1:0] x_last_r;
  logic [ZW-1:0] z_last_r;

  // Load start position and bounds, or step x then y then z.
  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      z         <= '0;
      y_first_r <= '0;
      y_last_r  <= '0;
      x_last_r  <= '0;
      z_last_r  <= '0;
    end else if (load) begin
      x         <= '0;
      y         <= y_first;
      z         <= '0;
      y_first_r <= y_first;
      y_last_r  <= y_last;
      x_last_r  <= x_last;
      z_last_r  <= z_last;
    end else if (en) begin
      if (x == x_last_r) begin
        x <= '0;
        if (y == y_last_r) begin
          y <= y_first_r;
          z <= z + 1'b1;
        end else begin
          y <= y + 1'b1;
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == x_last_r) && (y == y_last_r) && (z == z_last_r);

endmodule

// File: rtl/issue_sched.sv
// Convolution issue scheduler: hands output-position centres to free
// allocators in batches, then streams every pixel of the rows that batch
// touches, for every plane, to the downstream consumer.
// Handshake: a beat transfers on a cycle where issue_en and issue_ready are
// both 1; issue_en never drops and issue_x/y/z never change until then.
module issue_sched
  import issue_sched_pkg::*;
#(
  parameter int NUM_ALLOC = 28,
  parameter int COORD_W   = COORD_W_DEF,
  parameter int DEPTH_W   = DEPTH_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [COORD_W-1:0]   image_dim,
  input  logic [DEPTH_W-1:0]   image_depth,
  input  logic [1:0]           filter_halfsize,
  input  logic [2:0]           filter_stride,
  input  logic                 pad_mode,
  input  logic [NUM_ALLOC-1:0] issue_block,
  input  logic                 issue_ready,
  output logic [COORD_W-1:0]   positioner_x,
  output logic [COORD_W-1:0]   positioner_y,
  output logic [NUM_ALLOC-1:0] positioner_select,
  output logic [COORD_W-1:0]   issue_x,
  output logic [COORD_W-1:0]   issue_y,
  output logic [DEPTH_W-1:0]   issue_z,
  output logic                 issue_en,
  output logic                 busy,
  output logic                 done,
  output sched_state_t         dbg_state
);

  // One spare bit so h-subtraction and s-addition cannot wrap.
  localparam int W1  = COORD_W + 1;
  localparam int A_W = (NUM_ALLOC > 1) ? $clog2(NUM_ALLOC) : 1;
  localparam logic [A_W-1:0] A_LAST = A_W'(NUM_ALLOC - 1);

  sched_state_t state, state_nxt;

  // Values captured at start.
  logic [COORD_W-1:0] dim_r;
  logic [DEPTH_W-1:0] depth_last_r;
  logic [W1-1:0]      h_r, s_r, rs_r, re_r;

  // Position walker and batch bookkeeping.
  logic [W1-1:0]  pos_x, pos_y, first_y, last_y;
  logic           pos_more;
  logic [A_W-1:0] a;

  // Start-time decode of the raw inputs.
  logic [W1-1:0]      dim_w, h_in, s_in, rs_in, re_in;
  logic               empty_in;
  logic [DEPTH_W-1:0] depth_last_in;

  assign dim_w    = W1'(image_dim);
  assign h_in     = W1'(filter_halfsize);
  assign s_in     = (filter_stride == 3'd0) ? W1'(1) : W1'(filter_stride);
  assign rs_in    = (pad_mode == PAD_SAME) ? '0 : h_in;
  assign re_in    = (pad_mode == PAD_SAME) ? dim_w - W1'(1) : dim_w - W1'(1) - h_in;
  assign empty_in = (image_dim == '0) ||
                    ((pad_mode == PAD_VALID) && (dim_w < W1'({filter_halfsize, 1'b1})));
  assign depth_last_in = (image_depth == '0) ? '0 : image_depth - 1'b1;

  // Next position in raster order and whether the current one is the last.
  logic [W1-1:0] nx, ny;
  logic          wrap, pos_last;

  assign nx       = pos_x + s_r;
  assign ny       = pos_y + s_r;
  assign wrap     = nx > re_r;
  assign pos_last = wrap && (ny > re_r);

  // Row window of the current batch, clipped to the image.
  logic [W1-1:0]      row_hi_w, dim_last_w;
  logic [COORD_W-1:0] row_lo, row_hi;

  assign dim_last_w = W1'(dim_r) - W1'(1);
  assign row_hi_w   = last_y + h_r;
  assign row_lo     = (first_y >= h_r) ? COORD_W'(first_y - h_r) : '0;
  assign row_hi     = (row_hi_w > dim_last_w) ? COORD_W'(dim_last_w) : COORD_W'(row_hi_w);

  // Raster counter feeding the issue outputs.
  logic cnt_load, cnt_en, cnt_last;

  assign cnt_load = (state == ST_STREAM) && !issue_en;
  assign cnt_en   = (state == ST_STREAM) && issue_en && issue_ready && !cnt_last;

  issue_raster_cnt #(
    .XW (COORD_W),
    .YW (COORD_W),
    .ZW (DEPTH_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .en      (cnt_en),
    .y_first (row_lo),
    .y_last  (row_hi),
    .x_last  (dim_last_w[COORD_W-1:0]),
    .z_last  (depth_last_r),
    .x       (issue_x),
    .y       (issue_y),
    .z       (issue_z),
    .last    (cnt_last)
  );

  logic grant;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and allocator grant.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = empty_in ? ST_FINISH : ST_ASSIGN;
      end
      ST_ASSIGN: begin
        grant = !issue_block[a];
        if (grant && ((a == A_LAST) || pos_last)) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (issue_en && issue_ready && cnt_last)
          state_nxt = pos_more ? ST_ASSIGN : ST_FINISH;
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture config, walk positions, register all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dim_r             <= '0;
      depth_last_r      <= '0;
      h_r               <= '0;
      s_r               <= '0;
      rs_r              <= '0;
      re_r              <= '0;
      pos_x             <= '0;
      pos_y             <= '0;
      first_y           <= '0;
      last_y            <= '0;
      pos_more          <= 1'b0;
      a                 <= '0;
      positioner_x      <= '0;
      positioner_y      <= '0;
      positioner_select <= '0;
      issue_en          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      positioner_select <= grant ? (NUM_ALLOC'(1) << a) : '0;
      done              <= (state_nxt == ST_FINISH);
      busy              <= (state_nxt == ST_ASSIGN) || (state_nxt == ST_STREAM);
      case (state)
        ST_IDLE: begin
          if (start && !empty_in) begin
            dim_r        <= image_dim;
            depth_last_r <= depth_last_in;
            h_r          <= h_in;
            s_r          <= s_in;
            rs_r         <= rs_in;
            re_r         <= re_in;
            pos_x        <= rs_in;
            pos_y        <= rs_in;
            pos_more     <= 1'b1;
            a            <= '0;
          end
        end
        ST_ASSIGN: begin
          if (grant) begin
            positioner_x <= pos_x[COORD_W-1:0];
            positioner_y <= pos_y[COORD_W-1:0];
            if (a == '0) first_y <= pos_y;
            last_y <= pos_y;
            a      <= ((a == A_LAST) || pos_last) ? '0 : a + 1'b1;
            if (pos_last) begin
              pos_more <= 1'b0;
            end else if (wrap) begin
              pos_x <= rs_r;
              pos_y <= ny;
            end else begin
              pos_x <= nx;
            end
          end
        end
        ST_STREAM: begin
          if (!issue_en)                     issue_en <= 1'b1;
          else if (issue_ready && cnt_last)  issue_en <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched: each pass is compared against a small
// reference walk of the position set and row windows, plus hand-computed
// counts for the documented configurations.
module tb_issue_sched;
  import issue_sched_pkg::*;

  localparam int NA = 28;
  localparam int CW = 8;
  localparam int DW = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           start;
  logic [CW-1:0]  image_dim;
  logic [DW-1:0]  image_depth;
  logic [1:0]     filter_halfsize;
  logic [2:0]     filter_stride;
  logic           pad_mode;
  logic [NA-1:0]  issue_block;
  logic           issue_ready;
  logic [CW-1:0]  positioner_x, positioner_y, issue_x, issue_y;
  logic [NA-1:0]  positioner_select;
  logic [DW-1:0]  issue_z;
  logic           issue_en, busy, done;
  sched_state_t   dbg_state;

  issue_sched #(.NUM_ALLOC(NA), .COORD_W(CW), .DEPTH_W(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .image_dim         (image_dim),
    .image_depth       (image_depth),
    .filter_halfsize   (filter_halfsize),
    .filter_stride     (filter_stride),
    .pad_mode          (pad_mode),
    .issue_block       (issue_block),
    .issue_ready       (issue_ready),
    .positioner_x      (positioner_x),
    .positioner_y      (positioner_y),
    .positioner_select (positioner_select),
    .issue_x           (issue_x),
    .issue_y           (issue_y),
    .issue_z           (issue_z),
    .issue_en          (issue_en),
    .busy              (busy),
    .done              (done),
    .dbg_state         (dbg_state)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_sel_q[$];
  logic [31:0] act_sel_q[$];
  logic [31:0] exp_beat_q[$];
  logic [31:0] act_beat_q[$];

  int cyc = 0;
  int overlap, sel_bad, stab_bad, done_cnt, done_cyc, last_beat_cyc;
  int batches, batch0_beats, t4, t5;
  logic busy_at_done, seen3, beat_since_sel, prev_stall;
  logic [31:0] prev_beat;
  logic rand_ready = 1'b0;

  task automatic clear_mon();
    act_sel_q.delete();
    act_beat_q.delete();
    overlap = 0; sel_bad = 0; stab_bad = 0; done_cnt = 0; done_cyc = 0;
    last_beat_cyc = 0; batches = 0; batch0_beats = 0; t4 = -1; t5 = -1;
    busy_at_done = 1'bx; seen3 = 1'b0; beat_since_sel = 1'b0;
  endtask

  // Reference: position set in raster order, batched, with clipped row windows.
  task automatic build_model(input int dim, input int depth, input int h, input int s, input int pad);
    int ss, dd, lo, hi, nb, rlo, rhi;
    int px[$];
    int py[$];
    ss = (s == 0) ? 1 : s;
    dd = (depth == 0) ? 1 : depth;
    exp_sel_q.delete();
    exp_beat_q.delete();
    if (pad != 0) begin lo = 0; hi = dim - 1; end
    else          begin lo = h; hi = dim - 1 - h; end
    if (dim == 0 || hi < lo) return;
    for (int y = lo; y <= hi; y += ss)
      for (int x = lo; x <= hi; x += ss) begin
        px.push_back(x);
        py.push_back(y);
      end
    for (int b = 0; b < px.size(); b += NA) begin
      nb = (px.size() - b < NA) ? px.size() - b : NA;
      for (int k = 0; k < nb; k++)
        exp_sel_q.push_back(32'(k * 65536 + px[b+k] * 256 + py[b+k]));
      rlo = py[b] - h;
      if (rlo < 0) rlo = 0;
      rhi = py[b+nb-1] + h;
      if (rhi > dim - 1) rhi = dim - 1;
      for (int z = 0; z < dd; z++)
        for (int y = rlo; y <= rhi; y++)
          for (int x = 0; x < dim; x++)
            exp_beat_q.push_back(32'(z * 65536 + y * 256 + x));
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic compare_seq(input string tag);
    int n, mism;
    check_val({tag, "_sel_len"}, 64'(act_sel_q.size()), 64'(exp_sel_q.size()));
    n = (act_sel_q.size() < exp_sel_q.size()) ? act_sel_q.size() : exp_sel_q.size();
    mism = 0;
    for (int i = 0; i < n; i++) if (act_sel_q[i] !== exp_sel_q[i]) mism++;
    check_val({tag, "_sel_order_errs"}, 64'(mism), 64'd0);
    check_val({tag, "_beat_len"}, 64'(act_beat_q.size()), 64'(exp_beat_q.size()));
    n = (act_beat_q.size() < exp_beat_q.size()) ? act_beat_q.size() : exp_beat_q.size();
    mism = 0;
    for (int i = 0; i < n; i++) if (act_beat_q[i] !== exp_beat_q[i]) mism++;
    check_val({tag, "_beat_order_errs"}, 64'(mism), 64'd0);
    check_val({tag, "_overlap"}, 64'(overlap), 64'd0);
    check_val({tag, "_onehot_errs"}, 64'(sel_bad), 64'd0);
    check_val({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check_val({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int idx, n;
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (|positioner_select) begin
        idx = -1; n = 0;
        for (int i = 0; i < NA; i++) if (positioner_select[i]) begin idx = i; n++; end
        if (n != 1) sel_bad++;
        if (act_sel_q.size() == 0 || beat_since_sel) begin
          batches++;
          beat_since_sel = 1'b0;
        end
        act_sel_q.push_back(32'(idx * 65536 + int'(positioner_x) * 256 + int'(positioner_y)));
        if (batches == 1 && idx == 3) seen3 = 1'b1;
        if (batches == 1 && idx == 4) t4 = cyc;
        if (batches == 1 && idx == 5) t5 = cyc;
      end
      if (issue_en && |positioner_select) overlap++;
      if (prev_stall && !issue_en) stab_bad++;
      if (prev_stall && issue_en && ({7'd0, issue_z, issue_y, issue_x} != prev_beat)) stab_bad++;
      if (issue_en && issue_ready) begin
        act_beat_q.push_back({7'd0, issue_z, issue_y, issue_x});
        beat_since_sel = 1'b1;
        if (batches == 1) batch0_beats++;
        last_beat_cyc = cyc;
      end
      prev_stall = issue_en && !issue_ready;
      prev_beat  = {7'd0, issue_z, issue_y, issue_x};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
    end
  end

  // Downstream ready: constant 1 or pseudo-random.
  always @(posedge clk) begin
    #1;
    issue_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic run_pass(input int dim, input int depth, input int h, input int s,
                          input int pad, input bit mid_start);
    int t0;
    build_model(dim, depth, h, s, pad);
    clear_mon();
    @(posedge clk); #1;
    image_dim       = CW'(dim);
    image_depth     = DW'(depth);
    filter_halfsize = 2'(h);
    filter_stride   = 3'(s);
    pad_mode        = 1'(pad);
    start           = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the inputs: the pass must run on the sampled values.
    image_dim       = 8'd7;
    image_depth     = 9'd5;
    filter_halfsize = 2'd3;
    filter_stride   = 3'd2;
    pad_mode        = ~pad_mode;
    @(negedge clk);
    check_val("busy_after_start", 64'(busy), 64'(exp_sel_q.size() > 0));
    if (mid_start) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    t0 = cyc;
    while (done_cnt == 0 && (cyc - t0) < 40000) @(negedge clk);
    check_val("pass_timeout", 64'(done_cnt == 0), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k;
    rst = 1'b1; start = 1'b0; image_dim = '0; image_depth = '0;
    filter_halfsize = '0; filter_stride = '0; pad_mode = 1'b0; issue_block = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_select", 64'(positioner_select), 64'd0);
    check_val("rst_issue_en", 64'(issue_en), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_pos_xy", 64'({positioner_x, positioner_y}), 64'd0);
    check_val("rst_issue_xyz", 64'({issue_x, issue_y, issue_z}), 64'd0);
    check_val("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk); #1 rst = 1'b0;

    // Full valid-mode pass, with a start pulse mid-pass that must be ignored.
    run_pass(25, 3, 1, 1, 0, 1'b1);
    compare_seq("a");
    check_val("a_sel_total", 64'(act_sel_q.size()), 64'd529);
    check_val("a_batches", 64'(batches), 64'd19);
    check_val("a_batch0_beats", 64'(batch0_beats), 64'd300);
    check_val("a_first_sel", 64'(q_at(act_sel_q, 0)), 64'((0 << 16) | (1 << 8) | 1));
    check_val("a_sel27", 64'(q_at(act_sel_q, 27)), 64'((27 << 16) | (5 << 8) | 2));
    check_val("a_sel28", 64'(q_at(act_sel_q, 28)), 64'((0 << 16) | (6 << 8) | 2));

    // Allocator 5 blocked for 10 cycles just as it comes up in batch 0.
    fork
      begin
        int j;
        j = 0;
        while (!seen3 && j < 500) begin @(posedge clk); j++; end
        #1 issue_block[5] = 1'b1;
        repeat (10) @(posedge clk);
        #1 issue_block[5] = 1'b0;
      end
    join_none
    run_pass(25, 3, 1, 1, 0, 1'b0);
    compare_seq("b");
    check_val("b_stall_gap", 64'(t5 - t4), 64'd11);

    // Same-size padding with stride 3.
    run_pass(8, 1, 2, 3, 1, 1'b0);
    compare_seq("c");
    check_val("c_sel_total", 64'(act_sel_q.size()), 64'd9);
    check_val("c_beats", 64'(act_beat_q.size()), 64'd64);
    check_val("c_last_sel", 64'(q_at(act_sel_q, 8)), 64'((8 << 16) | (6 << 8) | 6));
    check_val("c_done_lat", 64'(done_cyc - last_beat_cyc), 64'd1);

    // Random backpressure: same stream, stable while stalled.
    rand_ready = 1'b1;
    run_pass(25, 3, 1, 1, 0, 1'b0);
    rand_ready = 1'b0;
    compare_seq("e");
    check_val("e_stable_errs", 64'(stab_bad), 64'd0);

    // Empty position sets.
    run_pass(3, 1, 2, 1, 0, 1'b0);
    check_val("d_done", 64'(done_cnt), 64'd1);
    check_val("d_sel", 64'(act_sel_q.size()), 64'd0);
    check_val("d_beats", 64'(act_beat_q.size()), 64'd0);
    run_pass(0, 1, 0, 1, 1, 1'b0);
    check_val("d0_done", 64'(done_cnt), 64'd1);
    check_val("d0_beats", 64'(act_beat_q.size() + act_sel_q.size()), 64'd0);

    // Stride 0 and depth 0 both behave as 1.
    run_pass(5, 0, 0, 0, 0, 1'b0);
    compare_seq("f");
    check_val("f_sel_total", 64'(act_sel_q.size()), 64'd25);
    check_val("f_beats", 64'(act_beat_q.size()), 64'd25);

    // Reset in the middle of streaming, then a clean pass.
    clear_mon();
    @(posedge clk); #1;
    image_dim = 8'd25; image_depth = 9'd3; filter_halfsize = 2'd1;
    filter_stride = 3'd1; pad_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (!issue_en && k < 500) begin @(negedge clk); k++; end
    check_val("r_reach_stream", 64'(issue_en), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("r_issue_en", 64'(issue_en), 64'd0);
    check_val("r_busy", 64'(busy), 64'd0);
    check_val("r_done", 64'(done), 64'd0);
    check_val("r_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check_val("r_no_done", 64'(done_cnt), 64'd0);
    run_pass(8, 1, 2, 3, 1, 1'b0);
    compare_seq("r");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 NUM_ALLOC, 28, number of allocators served.
REQ-002 COORD_W, 8, coordinate and image_dim width.
REQ-003 DEPTH_W, 9, image_depth and plane-index width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse; begins a convolution pass when idle.
REQ-007 image_dim  input  COORD_W  square image side length, sampled at start.
REQ-008 image_depth  input  DEPTH_W  plane count, sampled at start.
REQ-009 filter_halfsize  input  2  window radius h; window is (2h+1)x(2h+1).
REQ-010 filter_stride  input  3  output-position step s.
REQ-011 pad_mode  input  1  0 = valid-only positions, 1 = same-size (zero-padded) positions.
REQ-012 issue_block  input  NUM_ALLOC  per-allocator busy; allocator k is not assignable while bit k is 1.
REQ-013 issue_ready  input  1  downstream accepts the current issue beat.
REQ-014 positioner_x, positioner_y  output  COORD_W  assigned output-position centre.
REQ-015 positioner_select  output  NUM_ALLOC  one-hot allocator select, valid one cycle.
REQ-016 issue_x, issue_y  output  COORD_W  streamed pixel coordinate.
REQ-017 issue_z  output  DEPTH_W  streamed plane index.
REQ-018 issue_en  output  1  streamed beat valid.
REQ-019 busy  output  1  high from the cycle after accepted start until done.
REQ-020 done  output  1  one-cycle pulse when the pass completes.

Function
REQ-021 FSM states IDLE, ASSIGN, STREAM, FINISH; start accepted only in IDLE, ignored otherwise.
REQ-022 Sampled inputs: s=0 treated as 1; image_depth=0 treated as 1; inputs changing mid-pass have no effect.
REQ-023 Position set: pad_mode=0 -> x,y in [h, dim-1-h]; pad_mode=1 -> x,y in [0, dim-1]; both stepped by s from range start, raster order (x fastest).
REQ-024 Empty position set (dim < 2h+1 in valid mode, or dim=0) -> IDLE to FINISH directly, no select or issue beats.
REQ-025 ASSIGN: allocator index a starts at 0 each batch; per cycle, if issue_block[a]=0, drive positioner_select=one-hot(a) with next position, advance position, a=a+1; if issue_block[a]=1, stall (select all-zero), same a.
REQ-026 ASSIGN ends when a=NUM_ALLOC or positions exhausted; batch row range = [first_y-h, last_y+h] clipped to [0, dim-1].
REQ-027 STREAM: nested z 0..depth-1 (outer), y over batch row range, x 0..dim-1 (inner); issue_en=1 every STREAM cycle; beat advances only when issue_en and issue_ready both 1.
REQ-028 Outputs x/y/z hold stable while issue_en=1 and issue_ready=0.
REQ-029 After last beat accepted: positions remain -> ASSIGN (a=0); else FINISH.
REQ-030 FINISH lasts one cycle: done=1, busy=0; next state IDLE.
REQ-031 issue_en and positioner_select never both active in one cycle.
REQ-032 Coordinate arithmetic carried one bit wider than COORD_W so h-subtraction and s-addition never wrap; clipping uses the widened value.
REQ-033 All outputs registered; select/issue beats appear one cycle after the state-cycle that produced them is entered.

Reset
REQ-034 rst=1 at any time, including mid-pass, forces IDLE next edge, abandons the pass without done.
REQ-035 Reset values: positioner_select=0, issue_en=0, done=0, busy=0, positioner_x/y=0, issue_x/y/z=0, a=0.

Structure
REQ-036 Shared package holds FSM state encoding, pad_mode constants, and the default COORD_W/DEPTH_W values.
REQ-037 One sub-module, issue_raster_cnt: parametrised 3-level (z,y,x) counter with bounds, enable and last flag, used by STREAM.

Verification
REQ-038 dim=25, depth=3, h=1, s=1, pad=0, NUM_ALLOC=28, no block, ready=1 -> 529 positions, 19 batches; batch 0 selects (1,1)..(23,1),(1,2)..(5,2) to allocators 0..27, streams rows 0..3: 300 beats.
REQ-039 Same config, issue_block[5] held 1 for 10 cycles during batch 0 -> select stalls 10 cycles at a=5, then resumes; position order unchanged.
REQ-040 dim=8, depth=1, h=2, s=3, pad=1 -> positions x,y in {0,3,6}, 9 total, one batch; row range 0..7 clipped, 64 beats; done one cycle after last beat.
REQ-041 dim=3, h=2, pad=0 -> done pulse, zero selects, zero issue beats.
REQ-042 issue_ready toggled pseudo-randomly -> beat count and order identical to ready=1 run; outputs stable while stalled.
REQ-043 rst asserted mid-STREAM -> next cycle issue_en=0, busy=0, no done; new start runs full pass correctly.
